// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg: shared types and sizing helpers for the bit-stream deserializer
package bit_stream_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EMIT  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int DEF_IN_W  = 5;
   localparam int DEF_OUT_W = 16;

   function automatic int cnt_width(input int in_w, input int out_w);
      return $clog2(out_w + in_w);
   endfunction

endpackage

// File: rtl/bit_stream_deserializer.sv
// bit_stream_deserializer: reassembles LSB-first IN_W-bit chunks into OUT_W-bit words with flush
module bit_stream_deserializer
   import bit_stream_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = cnt_width(IN_W, OUT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_bits,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int ACC_W = OUT_W + IN_W - 1;

   state_e           state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] out_data_q;
   logic [CNT_W-1:0] out_bits_q;
   logic             out_last_q;
   logic             out_valid_q;
   logic [OUT_W-1:0] part_mask;
   logic             in_hs;
   logic             out_hs;

   assign in_ready  = rst_n & (state_q == FILL);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid_q & out_ready;
   assign part_mask = ~({OUT_W{1'b1}} << cnt_q);
   assign out_data  = out_data_q;
   assign out_bits  = out_bits_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

   // accumulator update: append a chunk above the residue, drop a consumed word, or clear after flush
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (state_q == FILL && in_hs) begin
         acc_d = acc_q | (ACC_W'(in_data) << cnt_q);
         cnt_d = cnt_q + CNT_W'(IN_W);
      end else if (state_q == EMIT && out_hs) begin
         acc_d = acc_q >> OUT_W;
         cnt_d = cnt_q - CNT_W'(OUT_W);
      end else if (state_q == FLUSH && out_hs) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   // control FSM with registered word outputs held until the consumer takes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_bits_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         case (state_q)
            FILL: begin
               if (in_hs && cnt_d >= CNT_W'(OUT_W)) begin
                  state_q     <= EMIT;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_d[OUT_W-1:0];
                  out_bits_q  <= CNT_W'(OUT_W);
                  out_last_q  <= 1'b0;
               end else if (!in_hs && flush && cnt_q != '0) begin
                  state_q     <= FLUSH;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_q[OUT_W-1:0] & part_mask;
                  out_bits_q  <= cnt_q;
                  out_last_q  <= 1'b1;
               end
            end
            EMIT, FLUSH: begin
               if (out_ready) begin
                  state_q     <= FILL;
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
                  out_bits_q  <= '0;
                  out_last_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= FILL;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // residue above the bit count must stay zero and the count must stay in range
   always_ff @(posedge clk) begin
      assert ((acc_q >> cnt_q) == '0);
      assert (cnt_q <= CNT_W'(OUT_W + IN_W - 1));
   end
`endif

endmodule

// File: tb/tb_bit_stream_deserializer.sv
// tb_bit_stream_deserializer: directed and random checks against a bit-queue reference model
module tb_bit_stream_deserializer;

   localparam int IN_W  = 5;
   localparam int OUT_W = 16;
   localparam int CNT_W = 5;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [CNT_W-1:0] bits;
      logic             last;
   } word_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             flush = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] out_bits;
   logic             out_last;
   logic             out_valid;
   logic             out_ready = 1'b0;

   int    npass = 0;
   int    ntotal = 0;
   int    nwords = 0;
   bit    model_bits[$];
   word_t exp_q[$];
   logic             stall = 1'b0;
   logic [OUT_W-1:0] sd;
   logic [CNT_W-1:0] sb;
   logic             sl;

   bit_stream_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // reference model: a plain FIFO of bits; words are the first OUT_W bits, flush takes whatever remains
   always @(negedge clk) begin
      word_t w;
      if (!rst_n) begin
         model_bits.delete();
         exp_q.delete();
         stall = 1'b0;
      end else begin
         chk("ready_vs_valid", in_ready, !out_valid);
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, sd);
            chk("hold_bits", out_bits, sb);
            chk("hold_last", out_last, sl);
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < IN_W; i++) model_bits.push_back(in_data[i]);
            if (model_bits.size() >= OUT_W) begin
               w = '0;
               for (int i = 0; i < OUT_W; i++) w.data[i] = model_bits.pop_front();
               w.bits = CNT_W'(OUT_W);
               exp_q.push_back(w);
            end
         end else if (flush && in_ready && model_bits.size() > 0) begin
            w = '0;
            w.bits = CNT_W'(model_bits.size());
            w.last = 1'b1;
            for (int i = 0; i < OUT_W && model_bits.size() > 0; i++) w.data[i] = model_bits.pop_front();
            exp_q.push_back(w);
         end
         if (out_valid && out_ready) begin
            nwords++;
            if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
            else begin
               w = exp_q.pop_front();
               chk("word_data", out_data, w.data);
               chk("word_bits", out_bits, w.bits);
               chk("word_last", out_last, w.last);
            end
         end
         stall = out_valid && !out_ready;
         sd = out_data;
         sb = out_bits;
         sl = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IN_W-1:0] c);
      bit done = 0;
      in_data  = c;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         done = in_ready;
         tick();
      end
      if (!done) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 200 && (exp_q.size() > 0 || out_valid); k++) tick();
      chk("drain_timeout", {exp_q.size() == 0, out_valid}, 2'b10);
   endtask

   initial begin
      logic [IN_W-1:0] r[5];
      logic [19:0]     v;
      logic [9:0]      v2;
      int              w0;
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_data", out_data, 0);
      chk("rst_bits", out_bits, 0);
      chk("rst_last", out_last, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", in_ready, 1);
      out_ready = 1'b1;

      send(5'h01); send(5'h02); send(5'h03); send(5'h04);
      chk("w1_valid", out_valid, 1);
      chk("w1_data", out_data, 16'h0C41);
      chk("w1_bits", out_bits, 16);
      chk("w1_last", out_last, 0);
      tick();
      chk("w1_gone", out_valid, 0);

      flush = 1'b1;
      tick();
      chk("fl1_valid", out_valid, 1);
      chk("fl1_data", out_data, 16'h0002);
      chk("fl1_bits", out_bits, 4);
      chk("fl1_last", out_last, 1);
      flush = 1'b0;
      tick();
      chk("fl1_done_valid", out_valid, 0);
      chk("fl1_done_ready", in_ready, 1);

      w0 = nwords;
      repeat (16) send(5'h1f);
      drain();
      chk("ones_words", nwords - w0, 5);

      for (int i = 0; i < 5; i++) r[i] = IN_W'($urandom);
      v = {r[3], r[2], r[1], r[0]};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(r[i]);
      in_data  = r[4];
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
         chk("stall_data", out_data, v[15:0]);
         tick();
      end
      out_ready = 1'b1;
      send(r[4]);
      flush = 1'b1;
      tick();
      chk("stall_fl_bits", out_bits, 9);
      chk("stall_fl_data", out_data, {7'd0, r[4], v[19:16]});
      flush = 1'b0;
      drain();

      flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("empty_flush", out_valid, 0);
      end
      flush = 1'b0;
      r[0] = IN_W'($urandom);
      r[1] = IN_W'($urandom);
      v2 = {r[1], r[0]};
      send(r[0]);
      flush = 1'b1;
      send(r[1]);
      chk("prio_absorb", out_valid, 0);
      tick();
      chk("prio_valid", out_valid, 1);
      chk("prio_bits", out_bits, 10);
      chk("prio_last", out_last, 1);
      chk("prio_data", out_data, {6'd0, v2});
      flush = 1'b0;
      drain();

      repeat (11) send(IN_W'($urandom));
      drain();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) r[i] = IN_W'($urandom);
      v = {r[3], r[2], r[1], r[0]};
      for (int i = 0; i < 4; i++) send(r[i]);
      chk("clean_valid", out_valid, 1);
      chk("clean_data", out_data, v[15:0]);
      drain();

      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = IN_W'($urandom);
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 12) == 0;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b1;
      repeat (6) tick();
      flush = 1'b0;
      drain();
      chk("final_pending", exp_q.size(), 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
